// File: rtl/arb_pkg.sv
// Shared types and sizing for the 16-way round-robin arbiter.
//   NUM_REQ     : number of requesters
//   IDX_W       : width of a requester index
//   arb_state_e : arbiter FSM state
package arb_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder.
//   decoder_i : binary index
//   decoder_o : one-hot output, bit decoder_i set
module decoder_4_16 (
  input  logic [3:0]  decoder_i,
  output logic [15:0] decoder_o
);

  always_comb begin
    decoder_o            = '0;
    decoder_o[decoder_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// A grant is held until the owner pulses done_i or drops its request; with
// MAX_HOLD != 0 an owner is preempted after MAX_HOLD cycles if others wait.
//   clk_i         : clock, rising edge
//   reset_i       : synchronous active-high reset
//   req_i         : request vector, bit n = requester n
//   done_i        : release pulse from the current owner
//   grant_o       : one-hot grant, zero when idle
//   grant_idx_o   : registered index of the current/last owner
//   grant_valid_o : high while a grant is active
//   preempt_o     : one-cycle pulse after a hold-limit revocation
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o,
  output logic               preempt_o
);

  localparam int unsigned   HoldW   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] others;
  logic               owner_req;
  logic               hold_hit;
  logic [NUM_REQ-1:0] dec_out;

  // First set bit scanning ptr, ptr+1, ... with natural 4-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    others    = req_i;
    others[idx_q] = 1'b0;
    owner_req = req_i[idx_q];
    hold_hit  = (MAX_HOLD != 0) && (hold_q == HoldMax) && (|others);

    unique case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          idx_d   = rr_pick(req_i, ptr_q);
          valid_d = 1'b1;
          hold_d  = HoldW'(1);
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (done_i || !owner_req || hold_hit) begin
          valid_d   = 1'b0;
          ptr_d     = idx_q + 1'b1;
          state_d   = ARB_IDLE;
          // Pulse only when the hold limit alone forced the release.
          preempt_d = hold_hit && !done_i && owner_req;
        end else if ((MAX_HOLD != 0) && (hold_q != HoldMax)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  decoder_4_16 u_decoder (
    .decoder_i (idx_q),
    .decoder_o (dec_out)
  );

  assign grant_o       = dec_out & {NUM_REQ{valid_q}};
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = valid_q;
  assign preempt_o     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16. Two instances share stimulus: dut4
// (MAX_HOLD=4) carries most checks, dut8 (default MAX_HOLD=8) is checked
// during the preemption sequence to show the limit follows the parameter.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic        done;

  logic [15:0] grant4, grant8;
  logic [3:0]  idx4, idx8;
  logic        valid4, valid8;
  logic        preempt4, preempt8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD(4)) dut4 (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .done_i        (done),
    .grant_o       (grant4),
    .grant_idx_o   (idx4),
    .grant_valid_o (valid4),
    .preempt_o     (preempt4)
  );

  rr_arbiter_16 dut8 (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .done_i        (done),
    .grant_o       (grant8),
    .grant_idx_o   (idx8),
    .grant_valid_o (valid8),
    .preempt_o     (preempt8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-tick values for the preemption sequence (req = 0x0006).
  logic [15:0] exp_g4 [15] = '{16'h2, 16'h2, 16'h2, 16'h2, 16'h0, 16'h4, 16'h4, 16'h4,
                               16'h4, 16'h0, 16'h2, 16'h2, 16'h2, 16'h2, 16'h0};
  logic        exp_p4 [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic [15:0] exp_g8 [15] = '{16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2,
                               16'h0, 16'h4, 16'h4, 16'h4, 16'h4, 16'h4, 16'h0};
  logic        exp_p8 [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    reset = 1'b1;
    req   = 16'hFFFF;
    done  = 1'b0;

    // Reset with all requests asserted.
    tick();
    tick();
    check_eq("rst_grant", grant4, 16'h0);
    check_eq("rst_valid", valid4, 1'b0);
    check_eq("rst_idx", idx4, 4'd0);
    check_eq("rst_preempt", preempt4, 1'b0);
    check_eq("rst_grant8", grant8, 16'h0);
    reset = 1'b0;
    tick();
    check_eq("first_idx", idx4, 4'd0);
    check_eq("first_grant", grant4, 16'h0001);
    req = 16'h0;
    tick();
    check_eq("drop_valid", valid4, 1'b0);
    check_eq("drop_idx_kept", idx4, 4'd0);
    check_eq("drop_ptr", dut4.ptr_q, 4'd1);

    // Single requester 4, done on the third grant cycle.
    req = 16'h0010;
    tick();
    check_eq("r4_c1", grant4, 16'h0010);
    tick();
    check_eq("r4_c2", grant4, 16'h0010);
    tick();
    check_eq("r4_c3", grant4, 16'h0010);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq("r4_bubble", grant4, 16'h0);
    check_eq("r4_ptr", dut4.ptr_q, 4'd5);
    check_eq("r4_no_preempt", preempt4, 1'b0);
    tick();
    check_eq("r4_regrant", grant4, 16'h0010);
    req = 16'h0;
    tick();

    // Full rotation with done every grant cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      logic [15:0] one;
      one = 16'h0001 << (k % 16);
      tick();
      check_eq($sformatf("rot_grant_%0d", k), grant4, one);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_eq($sformatf("rot_bubble_%0d", k), grant4, 16'h0);
    end

    // Wrap-around: release 14, then 0x4001 must go to 0.
    req = 16'h4000;
    tick();
    check_eq("wrap_idx14", idx4, 4'd14);
    req = 16'h0;
    tick();
    check_eq("wrap_ptr15", dut4.ptr_q, 4'd15);
    req = 16'h4001;
    tick();
    check_eq("wrap_idx0", idx4, 4'd0);
    check_eq("wrap_grant", grant4, 16'h0001);
    req = 16'h0;
    tick();

    // Preemption between requesters 1 and 2; done coincides with limit at end.
    req = 16'h0006;
    for (int t = 0; t < 15; t++) begin
      tick();
      check_eq($sformatf("hold4_grant_t%0d", t + 1), grant4, exp_g4[t]);
      check_eq($sformatf("hold4_preempt_t%0d", t + 1), preempt4, exp_p4[t]);
      check_eq($sformatf("hold8_grant_t%0d", t + 1), grant8, exp_g8[t]);
      check_eq($sformatf("hold8_preempt_t%0d", t + 1), preempt8, exp_p8[t]);
      done = (t == 13);
    end
    done = 1'b0;
    req  = 16'h0;
    tick();

    // Mid-grant reset.
    req = 16'h0100;
    tick();
    check_eq("mid_grant", grant4, 16'h0100);
    check_eq("mid_grant8", grant8, 16'h0100);
    req   = 16'h0101;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_grant", grant4, 16'h0);
    check_eq("mid_rst_valid", valid4, 1'b0);
    check_eq("mid_rst_idx", idx4, 4'd0);
    check_eq("mid_rst_preempt", preempt4, 1'b0);
    check_eq("mid_rst_ptr", dut4.ptr_q, 4'd0);
    tick();
    check_eq("post_rst_idx", idx4, 4'd0);
    check_eq("post_rst_grant", grant4, 16'h0001);
    check_eq("post_rst_grant8", grant8, 16'h0001);
    req = 16'h0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter that shares one resource among 16 requesters and drives a one-hot grant through the team's 4-to-16 decoder. Each grant is held until the owner signals completion or drops its request. An optional hold limit preempts an owner that keeps the grant too long while others are waiting. It sits between the 16 client ports and the shared resource's select lines.

## Interface
- MAX_HOLD, 8: maximum cycles one owner keeps the grant while another request is pending; 0 disables preemption.
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- req_i  in  16  request vector; bit n = requester n
- done_i  in  1  single-cycle pulse from the current owner to release the grant
- grant_o  out  16  one-hot grant, or all zeros when no grant
- grant_idx_o  out  4  registered index of the current owner
- grant_valid_o  out  1  high while a grant is active
- preempt_o  out  1  one-cycle pulse when a grant was forcibly revoked

## Operation
- State machine has two states:
  - ARB_IDLE: if req_i is nonzero, choose the first set bit scanning ptr, ptr+1, … wrapping mod 16. Register it into grant_idx_o, set grant_valid_o, go to ARB_GRANT, load hold_cnt=1. Otherwise stay idle.
  - ARB_GRANT: release when any of the following is true:
    - done_i=1
    - req_i[grant_idx_o]=0
    - MAX_HOLD≠0, hold_cnt==MAX_HOLD, and req_i has any other bit set
- On release:
  - grant_valid_o←0
  - ptr←(grant_idx_o+1) mod 16 (4-bit natural wrap)
  - state←ARB_IDLE
  - grant_idx_o keeps its last value
- Otherwise hold_cnt increments and saturates at MAX_HOLD.
- preempt_o=1 for exactly the IDLE cycle after a release caused only by the hold limit.
- If done_i, or a request drop, coincides with the hold limit, preempt_o stays 0.
- grant_o = decode(grant_idx_o) when grant_valid_o=1, else 16'h0000. It is never multi-hot.
- hold_cnt width is $clog2(MAX_HOLD+1), minimum 1.
- done_i in ARB_IDLE is ignored.
- Request bits that change during ARB_GRANT do not move the owner.
- Reset values:
  - state ARB_IDLE
  - ptr 0, hold_cnt 0
  - grant_idx_o 0, grant_valid_o 0, grant_o 0, preempt_o 0
- Reset mid-grant aborts the grant at that edge. No preempt_o pulse is produced.

## Timing
- Request to grant: req_i sampled at edge k → grant_valid_o/grant_o high after edge k+1 (1-cycle latency from IDLE).
- Release to regrant: release sampled at edge k → grant_o low after edge k+1 (one IDLE bubble) → next grant after edge k+2 at the earliest.
- Throughput: at most one grant per 2 cycles under continuous single-cycle ownership.
- grant_o is a combinational decode of registered state only. No path from req_i or done_i to any output within the same cycle.
- Preemption: owner granted after edge g is revoked after edge g+MAX_HOLD if competition persists.

## Structure
- arb_pkg holds:
  - NUM_REQ=16, IDX_W=4
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e
- Sub-module: one decoder_4_16 instance with decoder_i=grant_idx_o. Its output is ANDed with grant_valid_o to form grant_o.
- The rotating priority search is a function in the arbiter. No separate module.

## Test plan
- Reset with req_i=16'hFFFF held for 2 cycles → all outputs 0. After deassertion, grant_idx_o=0 and grant_o=16'h0001 one cycle later.
- req_i=16'h0010 only, done_i pulsed on the 3rd grant cycle → grant_o=16'h0010 for 3 cycles, 0 for 1 bubble, then 16'h0010 again; ptr=5.
- req_i=16'hFFFF, done_i each grant cycle → grant_o sequence 0x0001, 0x0002, … 0x8000, 0x0001, with one zero cycle between each.
- Wrap-around: after index 14 is granted and released (ptr=15), req_i=16'h4001 → grant_idx_o=0, grant_o=16'h0001.
- MAX_HOLD=4, req_i=16'h0006, no done_i:
  - idx 1 held for exactly 4 cycles
  - preempt_o pulses once
  - then idx 2 is granted for 4 cycles, preempt_o pulses again, then idx 1
  - with done_i on the 4th cycle instead, preempt_o stays 0
- Mid-grant reset while grant_o=16'h0100 → at the reset edge all outputs 0 and ptr=0. Next grant with req_i=16'h0101 goes to idx 0.
